// File: rtl/tril_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tril_pkg
// Brief    : Shared types and helpers for the lower-triangular operand streamer.
// Revision : 1.0
// ============================================================================
package tril_pkg;

    // Tags carry indices at a fixed width, so N is limited to 256.
    localparam int c_TAG_IDX_W = 8;

    function automatic int tril_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tril_terms(input int n);
        return (n * (n + 1) * (n + 2)) / 6;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tril_state_t;

    typedef struct packed {
        logic                   first;
        logic                   last;
        logic [c_TAG_IDX_W-1:0] row;
        logic [c_TAG_IDX_W-1:0] col;
    } tril_tag_t;

endpackage
`default_nettype wire

// File: rtl/tril_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tril_skid_fifo
// Brief    : Two-entry FIFO holding operand pairs with their tags.
// Revision : 1.0
// ============================================================================
module tril_skid_fifo
    import tril_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  tril_tag_t         i_tag,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output tril_tag_t         o_tag,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_a   [2];
    logic [DATA_W-1:0] r_b   [2];
    tril_tag_t         r_tag [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign w_push_ok = i_push && (r_count != 2'd2);
    assign w_pop_ok  = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                r_a[e]   <= '0;
                r_b[e]   <= '0;
                r_tag[e] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_a[r_wr_ptr]   <= i_a;
                r_b[r_wr_ptr]   <= i_b;
                r_tag[r_wr_ptr] <= i_tag;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    assign o_a     = r_a[r_rd_ptr];
    assign o_b     = r_b[r_rd_ptr];
    assign o_tag   = r_tag[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/tril_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tril_operand_streamer
// Brief    : Streams the non-zero A*B operand pairs of a lower-triangular matmul.
// Revision : 1.0
// ============================================================================
module tril_operand_streamer
    import tril_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int IDX_W  = tril_idx_w(N),
    parameter int ADDR_W = 2 * IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              first,
    output logic              last,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col
);

    localparam logic [IDX_W-1:0]  c_LAST = IDX_W'(N - 1);
    localparam logic [ADDR_W-1:0] c_N    = ADDR_W'(N);

    tril_state_t       r_state;
    tril_state_t       w_state_next;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_j;
    logic [IDX_W-1:0]  r_k;
    logic              r_inflight;
    tril_tag_t         r_inflight_tag;
    logic [DATA_W-1:0] w_head_a;
    logic [DATA_W-1:0] w_head_b;
    tril_tag_t         w_head_tag;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_issue;
    logic              w_final;
    logic [2:0]        w_occupancy;

    assign w_fifo_empty = (w_fifo_count == 2'd0);
    assign w_pop        = !w_fifo_empty && ready_in;
    // A head popped this cycle frees its slot before the read issued now lands.
    assign w_occupancy  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_final      = (r_i == c_LAST) && (r_j == c_LAST) && (r_k == c_LAST);
    assign w_issue      = mem_rd_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_issue && w_final) w_state_next = DRAIN;
            DRAIN:   if (w_fifo_empty && !r_inflight) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        mem_rd_en = (r_state == RUN) && (w_occupancy < 3'd2);
        done      = (r_state == DRAIN) && w_fifo_empty && !r_inflight;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_issue) begin
            if (w_final) begin
                r_i <= '0;
                r_j <= '0;
                r_k <= '0;
            end else if (r_k != r_i) begin
                r_k <= r_k + 1'b1;
            end else if (r_j != r_i) begin
                r_j <= r_j + 1'b1;
                r_k <= r_j + 1'b1;
            end else begin
                r_i <= r_i + 1'b1;
                r_j <= '0;
                r_k <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight     <= 1'b0;
            r_inflight_tag <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_tag.first <= (r_k == r_j);
                r_inflight_tag.last  <= (r_k == r_i);
                r_inflight_tag.row   <= c_TAG_IDX_W'(r_i);
                r_inflight_tag.col   <= c_TAG_IDX_W'(r_j);
            end
        end
    end

    assign a_addr = ADDR_W'(r_i) * c_N + ADDR_W'(r_k);
    assign b_addr = ADDR_W'(r_k) * c_N + ADDR_W'(r_j);

    tril_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_a     (a_rdata),
        .i_b     (b_rdata),
        .i_tag   (r_inflight_tag),
        .i_pop   (w_pop),
        .o_a     (w_head_a),
        .o_b     (w_head_b),
        .o_tag   (w_head_tag),
        .o_count (w_fifo_count)
    );

    assign valid_out = !w_fifo_empty;
    assign data_a    = w_head_a;
    assign data_b    = w_head_b;
    assign first     = w_head_tag.first;
    assign last      = w_head_tag.last;
    assign out_row   = IDX_W'(w_head_tag.row);
    assign out_col   = IDX_W'(w_head_tag.col);

endmodule
`default_nettype wire

// File: tb/tb_tril_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tril_operand_streamer
// Brief    : Scoreboard bench for tril_operand_streamer at N = 4, 1 and 8.
// Revision : 1.0
// ============================================================================
module tb_tril_operand_streamer;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic        last;
        logic [7:0]  row;
        logic [7:0]  col;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- N = 4 instance ----------------
    logic        rst4, start4, rdy4;
    logic        bz4, dn4, rd4, vo4, fi4, la4;
    logic [3:0]  aa4, ba4;
    logic [31:0] ra4, rb4, da4, db4;
    logic [1:0]  row4, col4;

    tril_operand_streamer #(.N(4), .DATA_W(32)) dut4 (
        .clk(clk), .rst_n(rst4), .start(start4), .busy(bz4), .done(dn4),
        .mem_rd_en(rd4), .a_addr(aa4), .b_addr(ba4), .a_rdata(ra4), .b_rdata(rb4),
        .valid_out(vo4), .ready_in(rdy4), .data_a(da4), .data_b(db4),
        .first(fi4), .last(la4), .out_row(row4), .out_col(col4)
    );

    // ---------------- N = 1 instance ----------------
    logic        rstx, start1, rdy1;
    logic        bz1, dn1, rd1, vo1, fi1, la1;
    logic [1:0]  aa1, ba1;
    logic [31:0] ra1, rb1, da1, db1;
    logic [0:0]  row1, col1;

    tril_operand_streamer #(.N(1), .DATA_W(32)) dut1 (
        .clk(clk), .rst_n(rstx), .start(start1), .busy(bz1), .done(dn1),
        .mem_rd_en(rd1), .a_addr(aa1), .b_addr(ba1), .a_rdata(ra1), .b_rdata(rb1),
        .valid_out(vo1), .ready_in(rdy1), .data_a(da1), .data_b(db1),
        .first(fi1), .last(la1), .out_row(row1), .out_col(col1)
    );

    // ---------------- N = 8 instance ----------------
    logic        start8, rdy8;
    logic        bz8, dn8, rd8, vo8, fi8, la8;
    logic [5:0]  aa8, ba8;
    logic [31:0] ra8, rb8, da8, db8;
    logic [2:0]  row8, col8;

    tril_operand_streamer #(.N(8), .DATA_W(32)) dut8 (
        .clk(clk), .rst_n(rstx), .start(start8), .busy(bz8), .done(dn8),
        .mem_rd_en(rd8), .a_addr(aa8), .b_addr(ba8), .a_rdata(ra8), .b_rdata(rb8),
        .valid_out(vo8), .ready_in(rdy8), .data_a(da8), .data_b(db8),
        .first(fi8), .last(la8), .out_row(row8), .out_col(col8)
    );

    // Synchronous operand RAMs: A[r][c] = 16r+c, B[r][c] = 256+16r+c.
    always @(posedge clk) begin
        if (rd4) begin
            ra4 <= 32'(16 * (aa4 / 4) + aa4 % 4);
            rb4 <= 32'(256 + 16 * (ba4 / 4) + ba4 % 4);
        end
        if (rd1) begin
            ra1 <= 32'(16 * aa1 + 0);
            rb1 <= 32'(256 + 16 * ba1);
        end
        if (rd8) begin
            ra8 <= 32'(16 * (aa8 / 8) + aa8 % 8);
            rb8 <= 32'(256 + 16 * (ba8 / 8) + ba8 % 8);
        end
    end

    exp_t q4[$];
    exp_t q1[$];
    exp_t q8[$];

    task automatic push_job(input int n);
        exp_t e;
        for (int i = 0; i < n; i++)
            for (int j = 0; j <= i; j++)
                for (int k = j; k <= i; k++) begin
                    e.a     = 32'(16 * i + k);
                    e.b     = 32'(256 + 16 * k + j);
                    e.first = (k == j);
                    e.last  = (k == i);
                    e.row   = 8'(i);
                    e.col   = 8'(j);
                    case (n)
                        1:       q1.push_back(e);
                        4:       q4.push_back(e);
                        default: q8.push_back(e);
                    endcase
                end
    endtask

    // ---------------- N = 4 monitor ----------------
    int           cyc = 0;
    int           hs4 = 0, done4 = 0, outst4 = 0;
    int           first_hs4 = 0, last_hs4 = 0;
    bit           stall_prev4 = 0;
    logic [127:0] hold4;
    exp_t         e4;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst4) begin
            stall_prev4 = 0;
            outst4      = 0;
        end else begin
            if (stall_prev4)
                chk("stall_hold4", {vo4, fi4, la4, row4, col4, da4, db4}, hold4);
            if (rd4)
                chk("credit4", 128'((outst4 - ((vo4 && rdy4) ? 1 : 0)) < 2), 128'(1));
            if (vo4 && rdy4) begin
                if (q4.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pair4_unexpected: got a=%0h b=%0h, expected no pair", da4, db4);
                end else begin
                    e4 = q4.pop_front();
                    chk("pair4", {da4, db4, fi4, la4, row4, col4},
                        {e4.a, e4.b, e4.first, e4.last, e4.row[1:0], e4.col[1:0]});
                    if (e4.row == 8'd0 && e4.col == 8'd0) first_hs4 = cyc;
                end
                hs4++;
                last_hs4 = cyc;
            end
            if (dn4) begin
                done4++;
                chk("done4_latency", 128'(cyc - last_hs4), 128'(1));
                chk("q4_empty_at_done", 128'(q4.size()), 128'(0));
            end
            outst4      = outst4 + (rd4 ? 1 : 0) - ((vo4 && rdy4) ? 1 : 0);
            stall_prev4 = vo4 && !rdy4;
            hold4       = {vo4, fi4, la4, row4, col4, da4, db4};
        end
    end

    // ---------------- N = 1 / N = 8 monitors ----------------
    int   hs1 = 0, done1 = 0, hs8 = 0, done8 = 0;
    int   sf8 = 0, sl8 = 0, diag8 = 0;
    exp_t e1, e8;

    always @(negedge clk) begin
        if (rstx) begin
            if (rd1) chk("n1_addr", {aa1, ba1}, 128'(0));
            if (vo1 && rdy1) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pair1_unexpected: got a=%0h, expected no pair", da1);
                end else begin
                    e1 = q1.pop_front();
                    chk("pair1", {da1, db1, fi1, la1, row1, col1},
                        {e1.a, e1.b, e1.first, e1.last, e1.row[0], e1.col[0]});
                end
                hs1++;
            end
            if (dn1) done1++;
            if (vo8 && rdy8) begin
                if (q8.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pair8_unexpected: got a=%0h, expected no pair", da8);
                end else begin
                    e8 = q8.pop_front();
                    chk("pair8", {da8, db8, fi8, la8, row8, col8},
                        {e8.a, e8.b, e8.first, e8.last, e8.row[2:0], e8.col[2:0]});
                end
                hs8++;
                if (fi8) sf8++;
                if (la8) sl8++;
                if (fi8 && la8) diag8++;
            end
            if (dn8) done8++;
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] pat = 16'b1001_1011_0010_1101;

    task automatic run4(input int mode, input int restart_at);
        int  d0;
        int  h0;
        bit  pulsed;
        d0     = done4;
        h0     = hs4;
        pulsed = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            start4 = 1'b0;
            rdy4   = (mode == 1) ? pat[t % 16] : 1'b1;
            if (restart_at > 0 && !pulsed && (hs4 - h0) >= restart_at) begin
                start4 = 1'b1;
                pulsed = 1;
            end
            if (done4 != d0) break;
        end
        chk("job4_done_count", 128'(done4 - d0), 128'(1));
        chk("job4_pairs", 128'(hs4 - h0), 128'(20));
    endtask

    initial begin
        int h0;
        start4 = 0; start1 = 0; start8 = 0;
        rdy4 = 1; rdy1 = 1; rdy8 = 1;
        rst4 = 0; rstx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset4", {bz4, dn4, rd4, vo4, aa4, ba4, da4}, 128'(0));
        chk("reset1", {bz1, dn1, rd1, vo1, aa1, ba1}, 128'(0));
        chk("reset8", {bz8, dn8, rd8, vo8, aa8, ba8}, 128'(0));
        rst4 = 1; rstx = 1;

        // N=4, ready held high: back-to-back pairs
        push_job(4);
        start4 = 1;
        run4(0, 0);
        chk("consecutive4", 128'(last_hs4 - first_hs4), 128'(19));

        // N=4, toggling backpressure
        push_job(4);
        start4 = 1;
        run4(1, 0);

        // start pulsed mid-job is ignored; start right after done runs a new job
        push_job(4);
        start4 = 1;
        run4(0, 5);
        push_job(4);
        start4 = 1;
        run4(0, 0);

        // reset with the FIFO full and the consumer stalled
        push_job(4);
        start4 = 1;
        h0 = hs4;
        for (int t = 0; t < 100 && (hs4 - h0) < 7; t++) begin
            @(posedge clk);
            #1;
            start4 = 0;
        end
        rdy4 = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("full_outstanding4", 128'(outst4), 128'(2));
        chk("full_valid4", 128'(vo4), 128'(1));
        rst4 = 0;
        q4.delete();
        @(posedge clk);
        #1;
        rst4 = 1;
        chk("post_reset4", {bz4, vo4, rd4}, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset4_idle", {bz4, vo4}, 128'(0));
        rdy4 = 1;
        push_job(4);
        start4 = 1;
        run4(0, 0);

        // N=1: a single diagonal pair
        push_job(1);
        start1 = 1;
        for (int t = 0; t < 50 && done1 == 0; t++) begin
            @(posedge clk);
            #1;
            start1 = 0;
        end
        chk("n1_pairs", 128'(hs1), 128'(1));
        chk("n1_done", 128'(done1), 128'(1));

        // N=8: 120 pairs, 36 first and 36 last markers, 8 diagonal pairs
        push_job(8);
        start8 = 1;
        for (int t = 0; t < 400 && done8 == 0; t++) begin
            @(posedge clk);
            #1;
            start8 = 0;
        end
        chk("n8_pairs", 128'(hs8), 128'(120));
        chk("n8_done", 128'(done8), 128'(1));
        chk("n8_sum_first", 128'(sf8), 128'(36));
        chk("n8_sum_last", 128'(sl8), 128'(36));
        chk("n8_diag", 128'(diag8), 128'(8));

        chk("q4_drained", 128'(q4.size()), 128'(0));
        chk("q1_drained", 128'(q1.size()), 128'(0));
        chk("q8_drained", 128'(q8.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
